// File: rtl/arcade_input_mapper.sv
// Debounces cabinet controls and packs them into per-game active-low input bytes.
// Raw-to-output latency is DEBOUNCE_CYCLES+2 cycles; there is no backpressure, every byte refreshes each cycle.
module arcade_input_mapper #(
  parameter int NUM_PLAYERS        = 4,
  parameter int DEBOUNCE_CYCLES    = 16,
  parameter int COIN_PULSE_CYCLES  = 4096,
  parameter int MODE_SETTLE_CYCLES = 16
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic [1:0]               game_mode,
  input  logic [4*NUM_PLAYERS-1:0] joy,
  input  logic [NUM_PLAYERS-1:0]   btn_start,
  input  logic [NUM_PLAYERS-1:0]   btn_fire,
  input  logic                     btn_coin,
  input  logic                     dip_wr,
  input  logic                     dip_addr,
  input  logic [7:0]               dip_data,
  output logic [7:0]               in_1,
  output logic [7:0]               in_2,
  output logic [7:0]               in_4,
  output logic                     coin_pulse
);

  localparam int NB = 6*NUM_PLAYERS + 1;
  localparam int COIN_BIT = NB - 1;
  localparam logic [7:0]  DB_LAST     = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  SETTLE_LOAD = 8'(MODE_SETTLE_CYCLES - 1);
  localparam logic [15:0] COIN_LOAD   = 16'(COIN_PULSE_CYCLES);

  logic [NB-1:0] raw, smp, filt;
  logic [7:0]    dcnt [NB];
  logic          coin_rise;

  assign raw = {btn_coin, btn_fire, btn_start, joy};

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      smp  <= '0;
      filt <= '0;
      for (int i = 0; i < NB; i++) dcnt[i] <= '0;
    end else begin
      smp <= raw;
      for (int i = 0; i < NB; i++) begin
        if (smp[i] == filt[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DB_LAST) begin
          filt[i] <= smp[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 8'd1;
        end
      end
    end
  end

  // Fires on the same edge the filtered coin bit goes high.
  assign coin_rise = smp[COIN_BIT] & ~filt[COIN_BIT] & (dcnt[COIN_BIT] == DB_LAST);

  logic [1:0] mode_q;
  logic [7:0] settle_cnt;
  logic       mode_chg, settling;

  assign mode_chg = (game_mode != mode_q);
  assign settling = mode_chg | (settle_cnt != 8'd0);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      mode_q     <= game_mode;
      settle_cnt <= '0;
    end else begin
      mode_q <= game_mode;
      if (mode_chg)
        settle_cnt <= SETTLE_LOAD;
      else if (settle_cnt != 8'd0)
        settle_cnt <= settle_cnt - 8'd1;
    end
  end

  logic [15:0] coin_cnt;
  logic        pulse_on;

  assign pulse_on = (coin_cnt != 16'd0);

  always_ff @(posedge clk_sys) begin
    if (!reset_n || settling)
      coin_cnt <= '0;
    else if (coin_rise && !pulse_on)
      coin_cnt <= COIN_LOAD;
    else if (pulse_on)
      coin_cnt <= coin_cnt - 16'd1;
  end

  logic [7:0] dip_a, dip_b, dip_a_nxt, dip_b_nxt;

  // Write-through so a DIP write shows on the very next output update.
  assign dip_a_nxt = (dip_wr && !dip_addr) ? dip_data : dip_a;
  assign dip_b_nxt = (dip_wr &&  dip_addr) ? dip_data : dip_b;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      dip_a <= 8'h00;
      dip_b <= 8'hF0;
    end else begin
      dip_a <= dip_a_nxt;
      dip_b <= dip_b_nxt;
    end
  end

  logic [15:0] j4;
  logic [3:0]  st4, fi4;

  always_comb begin
    j4  = '0;
    st4 = '0;
    fi4 = '0;
    j4[4*NUM_PLAYERS-1:0]  = filt[4*NUM_PLAYERS-1:0];
    st4[NUM_PLAYERS-1:0]   = filt[5*NUM_PLAYERS-1:4*NUM_PLAYERS];
    fi4[NUM_PLAYERS-1:0]   = filt[6*NUM_PLAYERS-1:5*NUM_PLAYERS];
  end

  wire unused_bits = ^{dip_a_nxt[7:4], fi4[3:2]};

  function automatic logic [3:0] ldru(input logic [15:0] j, input int p);
    return {j[4*p+1], j[4*p+2], j[4*p], j[4*p+3]};
  endfunction

  function automatic logic [3:0] uldr(input logic [15:0] j, input int p);
    return {j[4*p+3], j[4*p+1], j[4*p+2], j[4*p]};
  endfunction

  logic [7:0] map1, map2, map4;

  always_comb begin
    map1 = 8'hFF;
    map2 = 8'hFF;
    map4 = 8'hFF;
    case (mode_q)
      2'd0: begin
        map1 = ~{pulse_on, dip_a_nxt[2:0], 4'b0000};
        map2 = ~{ldru(j4, 0), ldru(j4, 1)};
      end
      2'd1: begin
        map1 = ~{pulse_on, 2'b00, |st4, dip_a_nxt[0], 3'b000};
        map2 = ~{ldru(j4, 1), ldru(j4, 0)};
        map4 = ~{ldru(j4, 3), ldru(j4, 2)};
      end
      2'd2: begin
        map1 = ~{pulse_on, 2'b00, st4[1], st4[0], dip_a_nxt[2:0]};
        map2 = ~{ldru(j4, 0), ldru(j4, 1)};
        map4 = dip_b_nxt;
      end
      default: begin
        map1 = ~{pulse_on, 3'b000, dip_a_nxt[3:0]};
        map2 = ~{fi4[0], st4[1], st4[0], 4'b0000, fi4[1]};
        map4 = ~{uldr(j4, 0), uldr(j4, 1)};
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n || settling) begin
      in_1       <= 8'hFF;
      in_2       <= 8'hFF;
      in_4       <= 8'hFF;
      coin_pulse <= 1'b0;
    end else begin
      in_1       <= map1;
      in_2       <= map2;
      in_4       <= map4;
      coin_pulse <= pulse_on;
    end
  end

endmodule
